// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS = 3'd4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with wrap-around pointers and an explicit count.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  // A pop on an empty FIFO is ignored; a push into a full one needs a same-cycle pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS register, TX FSM.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BASE_ADR     = 32'h0000_1000,
  parameter int               CLKS_PER_BIT = 868,
  parameter int               FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] rd_data,
  output logic             sel,
  output logic             tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          wr_tx, wr_st, pop, baud_done;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_cnt;

  assign sel   = (DataAdr[WIDTH-1:3] == BASE_ADR[WIDTH-1:3]);
  assign wr_tx = MemWrite && sel && ({DataAdr[2], 2'b00} == UART_TXDATA_OFS);
  assign wr_st = MemWrite && sel && ({DataAdr[2], 2'b00} == UART_STATUS_OFS);
  assign tx    = tx_q;

  sync_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    rd_data = '0;
    if (sel && ({DataAdr[2], 2'b00} == UART_STATUS_OFS)) begin
      rd_data[ST_BUSY]               = (state_q != IDLE);
      rd_data[ST_FULL]               = fifo_full;
      rd_data[ST_EMPTY]              = fifo_empty;
      rd_data[ST_OVF]                = ovf_q;
      rd_data[ST_CNT_LSB +: AW+1]    = fifo_cnt;
    end
  end

  assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: if (baud_done) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (baud_done) begin
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP: if (baud_done) begin
        // Chain straight into the next start bit when more data is waiting.
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (baud_done) baud_d = '0;

    // tx is registered from the next state so the line changes only on clock edges.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase

    ovf_d = ovf_q;
    if (wr_st && WriteData[ST_OVF])        ovf_d = 1'b0;
    if (wr_tx && fifo_full && !pop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench: written bytes are queued; a line monitor decodes frames on tx.
module tb_uart_mmio;
  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] rd_data;
  logic        sel;
  logic        tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames = 0;
  int fpos = -1;
  logic [7:0] rx;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_mmio #(.WIDTH(32), .BASE_ADR(B), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .rd_data(rd_data), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Frame monitor: fpos is the cycle index within the frame, sampled on negedge.
  always @(negedge clk) begin
    if (reset) fpos = -1;
    else if (fpos < 0) begin
      if (tx === 1'b0) begin
        fpos = 0;
        starts.push_back(cyc);
      end
    end else begin
      fpos++;
      if (fpos == 2) chk("start_bit", 32'(tx), 32'h0);
      else if (fpos >= 6 && fpos <= 34 && (fpos - 6) % 4 == 0) rx[(fpos - 6) / 4] = tx;
      else if (fpos == 38) begin
        chk("stop_bit", 32'(tx), 32'h1);
        frames++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame got=%h exp=none", rx);
        end else chk("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
      end else if (fpos == 39) fpos = -1;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    DataAdr = a; #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic wait_idle(input string nm, input int maxc, output int n);
    n = 0;
    DataAdr = B + 4;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rd_data[0] !== 1'b0 && n < maxc);
    if (rd_data[0] !== 1'b0) chk({nm, "_timeout"}, 32'(n), 32'(maxc + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, f0;
    logic stayed;

    // Reset
    repeat (3) @(posedge clk); #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk_rd("reset_status", B + 4, 32'h4);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single byte
    s0 = starts.size();
    wr(B, 32'hFFFF_FF55);
    exp_q.push_back(8'h55);
    chk("single_tx_before", 32'(tx), 32'h1);
    chk_rd("single_status_cnt1", B + 4, 32'h100);
    @(posedge clk); #1;
    chk("single_tx_fall", 32'(tx), 32'h0);
    chk_rd("single_status_busy", B + 4, 32'h5);
    wait_idle("single", 100, n);
    chk("single_len", 32'(n), 32'd40);
    chk_rd("single_status_end", B + 4, 32'h4);
    chk("single_q_empty", 32'(exp_q.size()), 32'h0);

    // Back-to-back
    s0 = starts.size();
    wr(B, 32'hA5);
    wr(B, 32'h0F);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h0F);
    wait_idle("b2b", 200, n);
    chk("b2b_len", 32'(n), 32'd80);
    if (starts.size() >= s0 + 2) chk("b2b_gap", 32'(starts[s0 + 1] - starts[s0]), 32'd40);
    else chk("b2b_starts", 32'(starts.size() - s0), 32'd2);
    chk("b2b_q_empty", 32'(exp_q.size()), 32'h0);

    // Overflow and clear
    f0 = frames;
    wr(B, 32'h11); wr(B, 32'h22); wr(B, 32'h33);
    wr(B, 32'h44); wr(B, 32'h55); wr(B, 32'h66);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    chk_rd("ovf_status", B + 4, 32'h40B);
    wr(B + 4, 32'h8);
    chk_rd("ovf_cleared", B + 4, 32'h403);
    wait_idle("ovf", 400, n);
    chk("ovf_frames", 32'(frames - f0), 32'd5);
    chk("ovf_q_empty", 32'(exp_q.size()), 32'h0);
    chk_rd("ovf_status_end", B + 4, 32'h4);

    // Decode
    DataAdr = B + 8; #1;
    chk("dec_sel_hi", 32'(sel), 32'h0);
    DataAdr = B - 4; #1;
    chk("dec_sel_lo", 32'(sel), 32'h0);
    f0 = frames;
    wr(B + 8, 32'h77);
    wr(B - 4, 32'h77);
    stayed = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) stayed = 1'b0;
    end
    chk("dec_tx_idle", 32'(stayed), 32'h1);
    chk_rd("dec_status", B + 4, 32'h4);
    chk_rd("dec_txdata_rd", B + 1, 32'h0);
    chk("dec_sel_b1", 32'(sel), 32'h1);
    chk_rd("dec_status_b5", B + 5, 32'h4);
    chk("dec_frames", 32'(frames - f0), 32'h0);

    // Reset mid-frame
    wr(B, 32'hC3);
    wr(B, 32'h3C);
    wr(B, 32'h99);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C); exp_q.push_back(8'h99);
    repeat (16) @(posedge clk); #1;
    chk("mid_data_bit3", 32'(tx), 32'h0);
    chk_rd("mid_status", B + 4, 32'h201);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_tx_after_reset", 32'(tx), 32'h1);
    chk_rd("mid_status_reset", B + 4, 32'h4);
    f0 = frames;
    stayed = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) stayed = 1'b0;
    end
    chk("mid_tx_idle", 32'(stayed), 32'h1);
    chk("mid_no_frames", 32'(frames - f0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART transmitter on the multicycle RISC-V core's data bus. It decodes the core's `MemWrite`/`DataAdr`/`WriteData` outputs and buffers written bytes in a small FIFO. Bytes are serialised 8N1 on `tx`. A status word is returned to the core's `ReadData` mux through `rd_data` and `sel`. It sits beside data memory, downstream of the core; the top level selects `rd_data` whenever `sel` is high.

## Interface
Parameters:
- `WIDTH`, 32: bus data/address width.
- `BASE_ADR`, 32'h0000_1000: base of an 8-byte register window; must be 8-byte aligned.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit, minimum 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, minimum 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: system clock.
  - `reset` in 1: synchronous, active-high.
- Bus inputs from the core:
  - `MemWrite` in 1: core write strobe, qualified by address decode.
  - `DataAdr` in WIDTH: core data address.
  - `WriteData` in WIDTH: core write data.
- Bus outputs to the top-level read mux:
  - `rd_data` out WIDTH: register read data; combinational from `DataAdr`.
  - `sel` out 1: `DataAdr` falls inside the window; combinational.
- Serial output:
  - `tx` out 1: serial line, idles high.

## Operation
Address decode:
- `sel` = (`DataAdr[WIDTH-1:3]` == `BASE_ADR[WIDTH-1:3]`).
- `DataAdr[2]` selects the register: 0 = TXDATA, 1 = STATUS.
- `DataAdr[1:0]` is ignored.

TXDATA (offset 0):
- Write: push `WriteData[7:0]`; the upper bits are ignored.
- Read: returns 0.
- Push when full with no same-cycle pop: the byte is dropped and sticky `overflow` is set.
- Push while full in the same cycle as a pop: the byte is accepted and the count is unchanged.

STATUS (offset 4), read:
- bit0 `busy`: state != IDLE.
- bit1 `full`.
- bit2 `empty`.
- bit3 `overflow`.
- bits[8+$clog2(FIFO_DEPTH):8]: FIFO count.
- All other bits: 0.

STATUS, write:
- `WriteData[3]`=1 clears `overflow`.
- If a clear and a new overflow happen in the same cycle, the set wins.

Transmit FSM (`uart_state_t`):
- IDLE:
  - `tx`=1.
  - If the FIFO is not empty: pop its head into `shift_reg` and go to START.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles, then DATA with `bit_idx`=0.
- DATA:
  - `tx`=`shift_reg[bit_idx]`, LSB first, for CLKS_PER_BIT cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - If the FIFO is not empty: pop and go to START directly, with no idle cycle.
  - Otherwise go to IDLE.

Counters:
- `baud_cnt` counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
- `bit_idx` is 3 bits.
- `tx` is driven from a register; it is glitch-free.

## Timing
- Reset values: `tx`=1, state IDLE, FIFO empty (count 0), `overflow`=0, `baud_cnt`=0, `bit_idx`=0.
- `rd_data` and `sel` have no reset value; they are purely combinational.
- Write latency: a TXDATA write is accepted at edge E0 with FIFO empty and state IDLE. The IDLE pop happens at E1, so `tx` falls after E1.
- Frame length: exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle. There is no gap.
- STATUS read timing: values reflect state registered at the preceding edge. A push at edge E shows in `count` from E onward.
- `busy` rises at the edge of the IDLE pop. It falls at the edge STOP→IDLE.
- Reset mid-frame: at the reset edge, `tx` returns to 1, the frame is aborted and FIFO contents are discarded.
- Reads have no side effects.

## Structure
Package `uart_pkg`:
- `uart_state_t` enum: IDLE, START, DATA, STOP.
- Register offsets: `UART_TXDATA_OFS`=0, `UART_STATUS_OFS`=4.
- STATUS bit indices: `ST_BUSY`, `ST_FULL`, `ST_EMPTY`, `ST_OVF`, `ST_CNT_LSB`=8.

Sub-module `sync_fifo`, parameterised:
- Parameters: data width, depth.
- Ports: `push`, `pop`, `din`, `dout` (head of FIFO, first-word-fall-through), `full`, `empty`, `count`.
- Implementation: wrap-around pointers plus an explicit count.
- Simultaneous push and pop is legal in every fill state except empty, where it is a push only.

`uart_mmio` contains the address decode, the STATUS logic, the FSM and the baud/bit counters.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset:
   - Hold `reset` 3 cycles.
   - `tx`=1; STATUS read at BASE+4 returns 0x0000_0004 (empty only).
2. Single byte:
   - Write 0x55 to BASE+0.
   - `tx` falls 1 cycle later. Bits read 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total). `busy`=1 throughout, then STATUS returns 0x4.
3. Back-to-back:
   - Write 0xA5 then 0x0F in consecutive cycles.
   - Two 40-cycle frames with no idle cycle between the 0xA5 stop bit and the 0x0F start bit.
4. Overflow and clear:
   - Write 6 bytes while idle.
   - The first byte pops, so 5 bytes are accepted and the 6th is dropped.
   - STATUS: `full`=1, `overflow`=1, `count`=4.
   - Write 0x8 to BASE+4: `overflow`=0.
   - Exactly 5 frames are transmitted.
5. Decode:
   - Write to BASE+8 and to BASE-4: `sel`=0, no push, `tx` stays 1.
   - Read BASE+1 (ignored low bits): returns TXDATA, value 0.
6. Reset mid-frame:
   - Assert `reset` during DATA bit 3 with 2 bytes queued.
   - `tx`=1 after the reset edge, STATUS=0x4, no further frames.
